// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment time multiplexer:
// segment decode table, off patterns and parameter defaults.
package seg_pkg;

  // 1 kHz slot rate from a 100 MHz clock, two anode-off cycles per slot
  localparam int DIV_DEFAULT = 100000;
  localparam int GAP_DEFAULT = 2;

  // Active-low patterns: every cathode / anode released
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} for values 0..15; 10..15 are not BCD and show a dash
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup; a blanked digit releases every cathode
  always_comb begin
    seg = SEG_TABLE[value];
    if (blank) begin
      seg = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg_time_mux.sv
// Four-digit seven-segment display multiplexer. Each digit gets DIV cycles,
// the first GAP of which keep all anodes off so the previous digit's
// cathode pattern cannot ghost onto the next position. Digits and decimal
// points are captured into shadow registers once per frame so a frame is
// never drawn from a mix of old and new input values.
module seg_time_mux
  import seg_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int GAP      = GAP_DEFAULT,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]   GAP_C    = CW'(GAP);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] sh_digit;
  logic [3:0]      sh_dp;

  logic            last_slot;
  logic            load;
  logic            in_gap;
  logic            lz_3;
  logic            lz_2;
  logic            lz_1;
  logic [3:0]      blank_vec;
  logic [3:0]      cur_digit;
  logic            cur_blank;
  logic [6:0]      dec_seg;

  // End of the current slot, and end of the whole four-slot frame
  assign last_slot  = (cnt == CNT_LAST);
  assign load       = last_slot && (idx == 2'd3);
  assign in_gap     = (cnt < GAP_C);
  // Reset aborts the frame, so the pulse is suppressed while it is held
  assign frame_done = load && !reset;

  // Slot counter wraps at DIV-1 and steps the digit index on each wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (last_slot) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Shadow capture once per frame, in the final cycle of slot 3
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_digit <= '0;
      sh_dp    <= '0;
    end else if (load) begin
      sh_digit <= {digit_3, digit_2, digit_1, digit_0};
      sh_dp    <= dp_en;
    end
  end

  // Leading-zero chain from the most significant digit down; digit 0 always shows
  assign lz_3 = BLANK_LZ && (sh_digit[3] == 4'd0);
  assign lz_2 = lz_3 && (sh_digit[2] == 4'd0);
  assign lz_1 = lz_2 && (sh_digit[1] == 4'd0);
  assign blank_vec = {lz_3, lz_2, lz_1, 1'b0};

  // Select the shadow digit for the active slot
  always_comb begin
    cur_digit = sh_digit[idx];
    cur_blank = blank_vec[idx];
  end

  seg7_decode u_decode (
    .value (cur_digit),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  // Registered pad drivers: one cycle behind the counter/index they decode
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (in_gap) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= dec_seg;
      dp  <= ~sh_dp[idx];
    end
  end

endmodule
